// File: rtl/serial_adder.sv
// Bit-serial adder/subtracter: one full adder plus a carry flip-flop, fed LSB first
// from operand shift registers; the finished word is latched into SUM/CARRY/OVERFLOW.

module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OVERFLOW
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    // Holds only the upper WIDTH-1 result bits; the newest bit arrives combinationally.
    logic [WIDTH-2:0] r_sr_reg;
    logic [CW-1:0]    count_reg;
    logic             cff_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             ovf_reg;

    logic             hs1_s;
    logic             hs1_c;
    logic             fa_s;
    logic             hs2_c;
    logic             fa_co;
    logic [WIDTH-1:0] r_cat;
    logic             last_bit;

    // Full adder: two half adders with the partial carries ORed.
    ha u_ha0 (
        .a (a_sr_reg[0]),
        .b (b_sr_reg[0]),
        .s (hs1_s),
        .c (hs1_c)
    );

    ha u_ha1 (
        .a (hs1_s),
        .b (cff_reg),
        .s (fa_s),
        .c (hs2_c)
    );

    assign fa_co    = hs1_c | hs2_c;
    assign r_cat    = {fa_s, r_sr_reg};
    assign last_bit = (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_reg <= ST_IDLE;
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            r_sr_reg  <= '0;
            count_reg <= '0;
            cff_reg   <= 1'b0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        // Subtraction is A + ~B + 1: invert B and preload the carry.
                        a_sr_reg  <= A;
                        b_sr_reg  <= B ^ {WIDTH{SUB}};
                        cff_reg   <= SUB;
                        count_reg <= '0;
                        state_reg <= ST_SHIFT;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sr_reg  <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg  <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    r_sr_reg  <= r_cat[WIDTH-1:1];
                    cff_reg   <= fa_co;
                    count_reg <= count_reg + CW'(1);
                    if (last_bit) begin
                        sum_reg   <= r_cat;
                        carry_reg <= fa_co;
                        ovf_reg   <= cff_reg ^ fa_co;
                        state_reg <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign BUSY     = (state_reg == ST_SHIFT);
    assign DONE     = (state_reg == ST_DONE);
    assign SUM      = sum_reg;
    assign CARRY    = carry_reg;
    assign OVERFLOW = ovf_reg;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder/subtracter for the SAP datapath. It is a low-gate-count alternative to the ripple adder-subtracter.
- Arithmetic core is one full adder built from two ha instances plus an OR gate for the carry. A carry flip-flop feeds that full adder back, and shift registers present one bit pair per clock, LSB first.
- Sits between the accumulator/B-register outputs and the bus. The result is latched into SUM/CARRY/OVERFLOW at completion.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).

Ports:
- CLK  input  1  rising-edge clock
- CLR_N  input  1  reset, asynchronous assert, active-low
- START  input  1  request an operation; sampled when not BUSY
- SUB  input  1  0 = A+B, 1 = A-B (two's complement); sampled with START
- A  input  WIDTH  first operand; sampled with START
- B  input  WIDTH  second operand; sampled with START
- BUSY  output  1  high while bits are being shifted
- DONE  output  1  one-cycle pulse when a new result is latched
- SUM  output  WIDTH  result of the last completed operation
- CARRY  output  1  final carry-out of the last completed operation
- OVERFLOW  output  1  signed overflow of the last completed operation

Behaviour:
- Reset (CLR_N low, async):
  - state=IDLE; all shift registers, bit counter and carry FF cleared.
  - BUSY=0, DONE=0, SUM=0, CARRY=0, OVERFLOW=0.
  - Reset mid-operation aborts the operation; no partial result reaches SUM.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with START=1 at a rising edge (load):
  - a_sr<=A; b_sr<=B XOR {WIDTH{SUB}}; carry FF<=SUB; count<=0; state<=SHIFT.
- IDLE with START=0: stay in IDLE. DONE with START=0: go to IDLE.
- SHIFT, each edge:
  - s = a_sr[0]^b_sr[0]^cff; co = majority(a_sr[0], b_sr[0], cff).
  - r_sr <= {s, r_sr[WIDTH-1:1]}; a_sr and b_sr shift right by one; cff<=co; count<=count+1.
  - On the final bit (count==WIDTH-1):
    - SUM<={s, r_sr[WIDTH-1:1]}; CARRY<=co; OVERFLOW<=cff^co (carry into MSB XOR carry out).
    - state<=DONE.
- START is ignored while in SHIFT. A, B and SUB may change freely after the load edge.
- Outputs:
  - BUSY=1 exactly in SHIFT; DONE=1 exactly in DONE. Both are registered state decodes.
  - SUM/CARRY/OVERFLOW change only on the final-bit edge; otherwise they hold.
- Latency:
  - START sampled at edge E0 → bits processed at E1..E_WIDTH → BUSY high for WIDTH cycles.
  - DONE and the new SUM are visible after E_WIDTH, i.e. WIDTH cycles after the load edge.
- Throughput: START held high gives back-to-back operations every WIDTH+1 cycles. The DONE cycle doubles as the next load cycle.
- Subtract:
  - CARRY=1 means no borrow (A>=B unsigned). CARRY=0 means borrow.
  - Result wraps modulo 2^WIDTH.
- Width rules: count is ceil(log2(WIDTH)) bits wide. No other state is retained between operations.

Test Plan:
- Add without carry (WIDTH=8): A=0x3C, B=0x0F, SUB=0, START pulse → BUSY high for 8 cycles, then DONE for 1 cycle; SUM=0x4B, CARRY=0, OVERFLOW=0.
- Add with wrap-around: A=0xFF, B=0x01, SUB=0 → SUM=0x00, CARRY=1, OVERFLOW=0. Then A=0x7F, B=0x01 → SUM=0x80, CARRY=0, OVERFLOW=1.
- Subtract:
  - A=0x10, B=0x01, SUB=1 → SUM=0x0F, CARRY=1, OVERFLOW=0.
  - A=0x01, B=0x02, SUB=1 → SUM=0xFF, CARRY=0.
  - A=0x80, B=0x01, SUB=1 → SUM=0x7F, OVERFLOW=1.
- START while busy:
  - Start 0x3C+0x0F.
  - Pulse START with A=0x00, B=0x00 on the 3rd BUSY cycle, and change A/B every cycle.
  - Expected: ignored; SUM=0x4B at the normal time; exactly one DONE pulse.
- Back-to-back: hold START=1 with A=0x01, B=0x01, then A=0x02, B=0x02 presented on the DONE cycle → DONE pulses 9 cycles apart; SUM=0x02, then 0x04; BUSY low only during DONE cycles.
- Reset mid-operation:
  - Complete 0x3C+0x0F (SUM=0x4B).
  - Start 0xFF+0x01 and assert CLR_N=0 asynchronously (between clock edges) after 4 shift cycles.
  - Expected: BUSY, DONE, SUM, CARRY and OVERFLOW go to 0 immediately.
  - After release, stays IDLE with no DONE until the next START, which completes normally.
